timestamp_packet_generator: RTL and testbench

Builds and serializes T2-MI timestamp packets (type 0x20) from parallel timestamp fields. It is the transmit-side counterpart of the timestamp extractor and sits on the T2-MI packet byte stream of the test/loopback path. It drives the same five-signal packet interface (valid/type/data/start/end). A packet emitted with the CRC feature compiled out is decoded unchanged by the extractor.

---
 rtl/timestamp_packet_generator.sv | 165 ++++++++++++++++
 tb/tb_timestamp_packet_generator.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/timestamp_packet_generator.sv
// timestamp_packet_generator: serializes T2-MI timestamp packets (type 0x20) from parallel fields.
// Optional CRC-32/MPEG-2 trailer enabled by defining T2MI_TS_CRC_EN.
`timescale 1ns/1ps
module timestamp_packet_generator #(
  parameter logic [7:0] TS_PACKET_TYPE = 8'h20,
  parameter int         GAP_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ts_valid,
  output logic        ts_ready,
  input  logic [3:0]  ts_bandwidth,
  input  logic [12:0] ts_utc_offset,
  input  logic [39:0] ts_seconds,
  input  logic [31:0] ts_subseconds,
  input  logic        tx_ready,
  output logic        packet_valid,
  output logic [7:0]  packet_type,
  output logic [7:0]  packet_data,
  output logic        packet_start,
  output logic        packet_end,
  output logic        ts_reject,
  output logic        tx_busy,
  output logic [7:0]  pkt_count
);
`ifdef T2MI_TS_CRC_EN
  typedef enum logic [2:0] {IDLE, START, PAYLOAD, CRC, END, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, PAYLOAD, END, GAP} state_t;
`endif
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  state_t      state, state_n;
  logic [3:0]  idx, idx_n;
  logic [7:0]  gcnt, gcnt_n;
  logic [3:0]  bw;
  logic [12:0] utco;
  logic [39:0] secs;
  logic [31:0] subsec;
  logic        accept;
  logic        valid_n, start_n, end_n, reject_n;
  logic [7:0]  type_n, data_n, count_n, pbyte;
  logic [95:0] payload, sh;
  assign payload  = {4'h0, bw, 3'b000, utco, secs, subsec};
  assign sh       = payload >> (7'd88 - {idx, 3'b000});
  assign pbyte    = sh[7:0];
  assign ts_ready = state == IDLE;
  assign tx_busy  = state != IDLE;
`ifdef T2MI_TS_CRC_EN
  logic [31:0] crc, crc_n;
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {d, 24'h0};
    for (int i = 0; i < 8; i++) r = r[31] ? {r[30:0], 1'b0} ^ 32'h04C11DB7 : {r[30:0], 1'b0};
    return r;
  endfunction
`endif
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    gcnt_n   = gcnt;
    accept   = 1'b0;
    valid_n  = 1'b0;
    start_n  = 1'b0;
    end_n    = 1'b0;
    reject_n = 1'b0;
    data_n   = 8'h00;
    type_n   = packet_type;
    count_n  = pkt_count;
`ifdef T2MI_TS_CRC_EN
    crc_n    = crc;
`endif
    case (state)
      IDLE: begin
        type_n = 8'h00;
        if (ts_valid && &ts_seconds) reject_n = 1'b1;
        else if (ts_valid) begin
          accept  = 1'b1;
          state_n = START;
        end
      end
      START: if (tx_ready) begin
        start_n = 1'b1;
        type_n  = TS_PACKET_TYPE;
        idx_n   = 4'd0;
        state_n = PAYLOAD;
`ifdef T2MI_TS_CRC_EN
        crc_n   = '1;
`endif
      end
      PAYLOAD: if (tx_ready) begin
        valid_n = 1'b1;
        data_n  = pbyte;
        idx_n   = idx == 4'd11 ? 4'd0 : idx + 4'd1;
`ifdef T2MI_TS_CRC_EN
        crc_n   = crc_step(crc, pbyte);
        state_n = idx == 4'd11 ? CRC : PAYLOAD;
`else
        state_n = idx == 4'd11 ? END : PAYLOAD;
`endif
      end
`ifdef T2MI_TS_CRC_EN
      CRC: if (tx_ready) begin
        valid_n = 1'b1;
        data_n  = crc[31:24];
        crc_n   = {crc[23:0], 8'h00};
        idx_n   = idx + 4'd1;
        state_n = idx == 4'd3 ? END : CRC;
      end
`endif
      END: if (tx_ready) begin
        end_n   = 1'b1;
        count_n = pkt_count + 8'd1;
        gcnt_n  = 8'd0;
        state_n = GAP_CYCLES == 0 ? IDLE : GAP;
      end
      GAP: begin
        type_n  = 8'h00;
        gcnt_n  = gcnt + 8'd1;
        state_n = gcnt == GAP_LAST ? IDLE : GAP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= 4'd0;
      gcnt         <= 8'd0;
      bw           <= 4'h0;
      utco         <= 13'h0;
      secs         <= 40'h0;
      subsec       <= 32'h0;
      packet_valid <= 1'b0;
      packet_start <= 1'b0;
      packet_end   <= 1'b0;
      ts_reject    <= 1'b0;
      packet_type  <= 8'h00;
      packet_data  <= 8'h00;
      pkt_count    <= 8'h00;
`ifdef T2MI_TS_CRC_EN
      crc          <= '1;
`endif
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      gcnt         <= gcnt_n;
      packet_valid <= valid_n;
      packet_start <= start_n;
      packet_end   <= end_n;
      ts_reject    <= reject_n;
      packet_type  <= type_n;
      packet_data  <= data_n;
      pkt_count    <= count_n;
`ifdef T2MI_TS_CRC_EN
      crc          <= crc_n;
`endif
      if (accept) begin
        bw     <= ts_bandwidth;
        utco   <= ts_utc_offset;
        secs   <= ts_seconds;
        subsec <= ts_subseconds;
      end
    end
  end
endmodule

// File: tb/tb_timestamp_packet_generator.sv
// tb_timestamp_packet_generator: directed bench for timestamp_packet_generator.
`timescale 1ns/1ps
module tb_timestamp_packet_generator;
  logic        clk = 1'b0, rst_n = 1'b0, ts_valid = 1'b0, tx_ready = 1'b1;
  logic [3:0]  ts_bandwidth = '0;
  logic [12:0] ts_utc_offset = '0;
  logic [39:0] ts_seconds = '0;
  logic [31:0] ts_subseconds = '0;
  logic        ts_ready, packet_valid, packet_start, packet_end, ts_reject, tx_busy;
  logic [7:0]  packet_type, packet_data, pkt_count;
`ifdef T2MI_TS_CRC_EN
  localparam int NB = 16;
`else
  localparam int NB = 12;
`endif
  localparam int END_CYC = NB + 2;
  localparam int PERIOD  = END_CYC + 3;
  int n_checks = 0, n_fail = 0;
  logic [7:0] got[16];
  logic [7:0] exp_b[16];
  int ngot, start_cyc, end_cyc;
  timestamp_packet_generator dut (
    .clk(clk), .rst_n(rst_n), .ts_valid(ts_valid), .ts_ready(ts_ready),
    .ts_bandwidth(ts_bandwidth), .ts_utc_offset(ts_utc_offset),
    .ts_seconds(ts_seconds), .ts_subseconds(ts_subseconds), .tx_ready(tx_ready),
    .packet_valid(packet_valid), .packet_type(packet_type), .packet_data(packet_data),
    .packet_start(packet_start), .packet_end(packet_end), .ts_reject(ts_reject),
    .tx_busy(tx_busy), .pkt_count(pkt_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input logic [3:0] b, input logic [12:0] u, input logic [39:0] s, input logic [31:0] f);
    ts_bandwidth = b; ts_utc_offset = u; ts_seconds = s; ts_subseconds = f;
  endtask
  // Expected payload from hand-written bytes; CRC bytes from a bit-serial model.
  task automatic set_exp(input logic [95:0] v);
    logic [31:0] c;
    logic fb;
    for (int i = 0; i < 12; i++) exp_b[i] = v[95-8*i -: 8];
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 12; i++)
      for (int j = 7; j >= 0; j--) begin
        fb = c[31] ^ exp_b[i][j];
        c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
      end
    for (int k = 0; k < 4; k++) exp_b[12+k] = c[31-8*k -: 8];
  endtask
  task automatic run_pkt(input logic [63:0] low_mask, input int exp_end, input logic [7:0] exp_count);
    ts_valid = 1'b1;
    step();
    ts_valid = 1'b0;
    chk("accept_busy", tx_busy, 1);
    chk("accept_ready", ts_ready, 0);
    ngot = 0; start_cyc = -1; end_cyc = -1;
    for (int c = 1; c < 60 && end_cyc < 0; c++) begin
      tx_ready = !low_mask[c];
      step();
      if (packet_start) start_cyc = c;
      if (packet_valid && ngot < 16) begin got[ngot] = packet_data; ngot++; end
      if (packet_end) end_cyc = c;
      if (low_mask[c]) chk($sformatf("bubble_e%0d", c), {packet_valid, packet_start, packet_end, packet_data, packet_type}, {3'b000, 8'h00, 8'h20});
    end
    tx_ready = 1'b1;
    chk("start_cycle", start_cyc, 1);
    chk("end_cycle", end_cyc, exp_end);
    chk("end_type", packet_type, 8'h20);
    chk("pkt_count", pkt_count, exp_count);
    chk("byte_count", ngot, NB);
    for (int i = 0; i < NB; i++) chk($sformatf("byte%0d", i), got[i], exp_b[i]);
    step();
    chk("gap_type", {packet_type, packet_end, ts_ready}, {8'h00, 1'b0, 1'b0});
    step();
    chk("gap_done_ready", ts_ready, 1);
  endtask
  initial begin
    int last, bad, ends;
    logic saw0;
    repeat (3) step();
    chk("reset_flags", {ts_ready, packet_valid, packet_start, packet_end, ts_reject, tx_busy}, 6'b100000);
    chk("reset_bytes", {packet_type, packet_data, pkt_count}, 24'h0);
    rst_n = 1'b1;
    step();
    set_req(4'd3, 13'h0025, 40'h002A3B4C5D, 32'h80000000);
    set_exp(96'h030025002A3B4C5D80000000);
    run_pkt(64'h0, END_CYC, 8'd1);
    run_pkt(64'h88, END_CYC + 2, 8'd2);
    set_req(4'd3, 13'h0025, 40'hFFFFFFFFFF, 32'h80000000);
    ts_valid = 1'b1;
    step();
    ts_valid = 1'b0;
    chk("reject_pulse", {ts_reject, ts_ready, tx_busy}, 3'b110);
    step();
    chk("reject_end", {ts_reject, packet_start, tx_busy, pkt_count}, {3'b000, 8'd2});
    set_req(4'd3, 13'h0025, 40'h002A3B4C5D, 32'h80000000);
    last = -1; bad = 0; ends = 0; saw0 = 1'b0;
    ts_valid = 1'b1;
    for (int c = 0; c < 256 * PERIOD + 40 && ends < 256; c++) begin
      step();
      if (packet_start) begin
        if (last >= 0 && c - last != PERIOD) bad++;
        last = c;
      end
      if (packet_end) begin
        ends++;
        if (pkt_count == 8'd0) saw0 = 1'b1;
      end
    end
    ts_valid = 1'b0;
    chk("b2b_packets", ends, 256);
    chk("b2b_period_errors", bad, 0);
    chk("b2b_wrap_seen", saw0, 1);
    chk("b2b_count", pkt_count, 8'd2);
    repeat (3) step();
    ts_valid = 1'b1;
    step();
    ts_valid = 1'b0;
    repeat (7) step();
    chk("pre_reset_b5", {packet_valid, packet_data}, {1'b1, 8'h3B});
    rst_n = 1'b0;
    #1;
    chk("async_reset_flags", {ts_ready, packet_valid, packet_start, packet_end, ts_reject, tx_busy}, 6'b100000);
    chk("async_reset_bytes", {packet_type, packet_data, pkt_count}, 24'h0);
    step();
    step();
    chk("held_reset_no_end", {packet_end, tx_busy, pkt_count}, 10'h0);
    rst_n = 1'b1;
    step();
    set_req(4'hA, 13'h1FFF, 40'hFFFFFFFFFE, 32'hDEADBEEF);
    set_exp(96'h0A1FFFFFFFFFFFFEDEADBEEF);
    run_pkt(64'h0, END_CYC, 8'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
